// File: rtl/cnn_mul_share_arb.sv
// Round-robin scheduler time-sharing one external combinational multiplier
// among NUM_REQ requesters through a two-stage (operand, result) pipeline.
module cnn_mul_share_arb #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DIN0_WIDTH = 5,
  parameter int unsigned DIN1_WIDTH = 7,
  parameter int unsigned DOUT_WIDTH = 11,
  parameter int unsigned TAG_WIDTH  = $clog2(NUM_REQ)
) (
  input  logic                             ap_clk,
  input  logic                             ap_rst_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*DIN0_WIDTH-1:0]    req_din0,
  input  logic [NUM_REQ*DIN1_WIDTH-1:0]    req_din1,
  output logic [DIN0_WIDTH-1:0]            mul_din0,
  output logic [DIN1_WIDTH-1:0]            mul_din1,
  input  logic [DOUT_WIDTH-1:0]            mul_dout,
  output logic [NUM_REQ-1:0]               rsp_valid,
  input  logic [NUM_REQ-1:0]               rsp_ready,
  output logic [DOUT_WIDTH-1:0]            rsp_dout,
  output logic [TAG_WIDTH-1:0]             rsp_tag
);

  logic                  s1_valid_q, s1_valid_d;
  logic [TAG_WIDTH-1:0]  s1_tag_q,   s1_tag_d;
  logic [DIN0_WIDTH-1:0] op0_q,      op0_d;
  logic [DIN1_WIDTH-1:0] op1_q,      op1_d;
  logic                  s2_valid_q, s2_valid_d;
  logic [TAG_WIDTH-1:0]  rsp_tag_q,  rsp_tag_d;
  logic [DOUT_WIDTH-1:0] rsp_dout_q, rsp_dout_d;
  logic [TAG_WIDTH-1:0]  ptr_q,      ptr_d;

  logic                  s2_adv_c;
  logic                  s1_adv_c;
  logic                  accept_c;
  logic                  grant_found;
  logic [TAG_WIDTH-1:0]  grant_idx;
  logic [TAG_WIDTH-1:0]  scan_idx;

  logic [DIN0_WIDTH-1:0] din0_arr [NUM_REQ];
  logic [DIN1_WIDTH-1:0] din1_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign din0_arr[g] = req_din0[g*DIN0_WIDTH +: DIN0_WIDTH];
    assign din1_arr[g] = req_din1[g*DIN1_WIDTH +: DIN1_WIDTH];
  end

  // Only the result owner's ready matters; this is the sole path from rsp_ready to req_ready.
  assign s2_adv_c = !s2_valid_q || rsp_ready[rsp_tag_q];
  assign s1_adv_c = !s1_valid_q || s2_adv_c;
  assign accept_c = s1_adv_c && grant_found;

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      scan_idx = TAG_WIDTH'((32'(ptr_q) + k) % NUM_REQ);
      if (!grant_found && req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  assign req_ready = (accept_c && ap_rst_n) ? (NUM_REQ'(1) << grant_idx) : '0;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_tag_d   = s1_tag_q;
    op0_d      = op0_q;
    op1_d      = op1_q;
    ptr_d      = ptr_q;
    s2_valid_d = s2_valid_q;
    rsp_tag_d  = rsp_tag_q;
    rsp_dout_d = rsp_dout_q;

    if (s1_adv_c) begin
      if (accept_c) begin
        s1_valid_d = 1'b1;
        s1_tag_d   = grant_idx;
        op0_d      = din0_arr[grant_idx];
        op1_d      = din1_arr[grant_idx];
        ptr_d      = grant_idx;
      end else begin
        // Idle multiplier inputs are forced to zero so they stay deterministic.
        s1_valid_d = 1'b0;
        op0_d      = '0;
        op1_d      = '0;
      end
    end

    if (s2_adv_c) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        rsp_tag_d  = s1_tag_q;
        rsp_dout_d = mul_dout;
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      s1_valid_q <= 1'b0;
      s1_tag_q   <= '0;
      op0_q      <= '0;
      op1_q      <= '0;
      ptr_q      <= TAG_WIDTH'(NUM_REQ - 1);
      s2_valid_q <= 1'b0;
      rsp_tag_q  <= '0;
      rsp_dout_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_tag_q   <= s1_tag_d;
      op0_q      <= op0_d;
      op1_q      <= op1_d;
      ptr_q      <= ptr_d;
      s2_valid_q <= s2_valid_d;
      rsp_tag_q  <= rsp_tag_d;
      rsp_dout_q <= rsp_dout_d;
    end
  end

  assign mul_din0  = op0_q;
  assign mul_din1  = op1_q;
  assign rsp_dout  = rsp_dout_q;
  assign rsp_tag   = rsp_tag_q;
  assign rsp_valid = s2_valid_q ? (NUM_REQ'(1) << rsp_tag_q) : '0;

endmodule

// File: tb/tb_cnn_mul_share_arb.sv
// Directed bench for cnn_mul_share_arb; the shared multiplier is modelled here
// as a truncating 5x7 product feeding mul_dout.
module tb_cnn_mul_share_arb;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [19:0] req_din0;
  logic [27:0] req_din1;
  logic [4:0]  mul_din0;
  logic [6:0]  mul_din1;
  logic [10:0] mul_dout;
  logic [3:0]  rsp_valid;
  logic [3:0]  rsp_ready;
  logic [10:0] rsp_dout;
  logic [1:0]  rsp_tag;

  logic [11:0] full_prod;
  assign full_prod = {7'd0, mul_din0} * {5'd0, mul_din1};
  assign mul_dout  = full_prod[10:0];

  int n_assert = 0;
  int n_fail   = 0;

  cnn_mul_share_arb dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_din0  (req_din0),
    .req_din1  (req_din1),
    .mul_din0  (mul_din0),
    .mul_din1  (mul_din1),
    .mul_dout  (mul_dout),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_dout  (rsp_dout),
    .rsp_tag   (rsp_tag)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_ops(input int i, input logic [4:0] a, input logic [6:0] b);
    req_din0[i*5 +: 5] = a;
    req_din1[i*7 +: 7] = b;
  endtask

  initial begin
    int prod_tbl [4];
    prod_tbl = '{12, 30, 56, 90};

    ap_rst_n  = 1'b0;
    req_valid = 4'hF;
    rsp_ready = 4'hF;
    req_din0  = '0;
    req_din1  = '0;
    set_ops(0, 5'd3, 7'd4);
    set_ops(1, 5'd5, 7'd6);
    set_ops(2, 5'd7, 7'd8);
    set_ops(3, 5'd9, 7'd10);

    // Reset state with every requester asking
    tick();
    tick();
    chk("rst_req_ready", req_ready, 4'b0000);
    chk("rst_rsp_valid", rsp_valid, 4'b0000);
    chk("rst_mul_din0", mul_din0, 0);
    chk("rst_mul_din1", mul_din1, 0);
    chk("rst_rsp_dout", rsp_dout, 0);
    chk("rst_rsp_tag", rsp_tag, 0);
    ap_rst_n = 1'b1;
    #1;
    chk("rel_first_grant", req_ready, 4'b0001);

    // Fairness: all valid, grants rotate 0..3, results two cycles later
    for (int k = 0; k < 8; k++) begin
      if (k == 6) req_valid = 4'b0000;
      #1;
      if (k < 6) chk("rr_req_ready", req_ready, 32'(1) << (k % 4));
      else       chk("rr_req_ready_idle", req_ready, 4'b0000);
      if (k == 1) chk("rr_mul_din0", mul_din0, 3);
      if (k >= 2) begin
        chk("rr_rsp_valid", rsp_valid, 32'(1) << ((k - 2) % 4));
        chk("rr_rsp_tag", rsp_tag, (k - 2) % 4);
        chk("rr_rsp_dout", rsp_dout, prod_tbl[(k - 2) % 4]);
      end else begin
        chk("rr_rsp_valid_early", rsp_valid, 4'b0000);
      end
      tick();
    end
    chk("rr_drained", rsp_valid, 4'b0000);
    chk("rr_idle_mul_din0", mul_din0, 0);

    // Single request from requester 2: 5 x 7
    set_ops(2, 5'd5, 7'd7);
    req_valid = 4'b0100;
    #1;
    chk("one_req_ready", req_ready, 4'b0100);
    tick();
    req_valid = 4'b0000;
    #1;
    chk("one_mul_din0", mul_din0, 5);
    chk("one_mul_din1", mul_din1, 7);
    chk("one_rsp_valid_c1", rsp_valid, 4'b0000);
    tick();
    chk("one_rsp_valid", rsp_valid, 4'b0100);
    chk("one_rsp_tag", rsp_tag, 2);
    chk("one_rsp_dout", rsp_dout, 35);
    tick();
    chk("one_done", rsp_valid, 4'b0000);

    // Truncation corners: 31x127, 0x127, 31x1 (order 3,0,1 from ptr=2)
    set_ops(3, 5'd31, 7'd127);
    set_ops(0, 5'd0, 7'd127);
    set_ops(1, 5'd31, 7'd1);
    req_valid = 4'b1011;
    #1;
    chk("tr_grant3", req_ready, 4'b1000);
    tick();
    req_valid = 4'b0011;
    #1;
    chk("tr_grant0", req_ready, 4'b0001);
    tick();
    req_valid = 4'b0010;
    #1;
    chk("tr_grant1", req_ready, 4'b0010);
    chk("tr_rsp_valid_a", rsp_valid, 4'b1000);
    chk("tr_31x127", rsp_dout, 1889);
    tick();
    req_valid = 4'b0000;
    #1;
    chk("tr_rsp_valid_b", rsp_valid, 4'b0001);
    chk("tr_0x127", rsp_dout, 0);
    tick();
    chk("tr_rsp_valid_c", rsp_valid, 4'b0010);
    chk("tr_31x1", rsp_dout, 31);
    tick();
    chk("tr_done", rsp_valid, 4'b0000);

    // Backpressure: owner (req2) not ready, other ready bits must be ignored
    set_ops(2, 5'd2, 7'd3);
    set_ops(3, 5'd4, 7'd5);
    set_ops(0, 5'd6, 7'd7);
    rsp_ready = 4'b1011;
    req_valid = 4'b1101;
    #1;
    chk("bp_grant2", req_ready, 4'b0100);
    tick();
    req_valid = 4'b1001;
    #1;
    chk("bp_grant3", req_ready, 4'b1000);
    chk("bp_mul_din0_a", mul_din0, 2);
    tick();
    req_valid = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_stall_ready", req_ready, 4'b0000);
      chk("bp_stall_rsp_valid", rsp_valid, 4'b0100);
      chk("bp_stall_rsp_dout", rsp_dout, 6);
      chk("bp_stall_mul_din0", mul_din0, 4);
      chk("bp_stall_mul_din1", mul_din1, 5);
      tick();
    end
    rsp_ready = 4'hF;
    #1;
    chk("bp_release_grant0", req_ready, 4'b0001);
    chk("bp_release_rsp_dout", rsp_dout, 6);
    tick();
    req_valid = 4'b0000;
    #1;
    chk("bp_drain_valid_a", rsp_valid, 4'b1000);
    chk("bp_drain_dout_a", rsp_dout, 20);
    chk("bp_drain_mul_din0", mul_din0, 6);
    tick();
    chk("bp_drain_valid_b", rsp_valid, 4'b0001);
    chk("bp_drain_dout_b", rsp_dout, 42);
    tick();
    chk("bp_drain_done", rsp_valid, 4'b0000);

    // Async reset with S1 and S2 both occupied
    set_ops(1, 5'd11, 7'd13);
    set_ops(2, 5'd2, 7'd2);
    rsp_ready = 4'b0000;
    req_valid = 4'b0110;
    #1;
    chk("ar_grant1", req_ready, 4'b0010);
    tick();
    req_valid = 4'b0100;
    #1;
    chk("ar_grant2", req_ready, 4'b0100);
    tick();
    req_valid = 4'b1110;
    #1;
    chk("ar_full_rsp_valid", rsp_valid, 4'b0010);
    ap_rst_n = 1'b0;
    #1;
    chk("ar_rst_rsp_valid", rsp_valid, 4'b0000);
    chk("ar_rst_req_ready", req_ready, 4'b0000);
    chk("ar_rst_mul_din0", mul_din0, 0);
    chk("ar_rst_rsp_dout", rsp_dout, 0);
    tick();
    ap_rst_n  = 1'b1;
    rsp_ready = 4'hF;
    set_ops(1, 5'd6, 7'd5);
    req_valid = 4'b1010;
    #1;
    chk("ar_post_grant", req_ready, 4'b0010);
    tick();
    req_valid = 4'b0000;
    #1;
    chk("ar_no_stale_rsp", rsp_valid, 4'b0000);
    chk("ar_post_mul_din0", mul_din0, 6);
    tick();
    chk("ar_post_rsp_valid", rsp_valid, 4'b0010);
    chk("ar_post_rsp_dout", rsp_dout, 30);
    tick();
    chk("ar_post_done", rsp_valid, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
